// File: rtl/interval_timer.sv
// interval_timer
//   Programmable interval timer for the RMII/MII receive path. It times frame
//   gaps, preamble windows and byte-count intervals. A run is requested with
//   start and counts from 0 up to the captured terminal value. Each count step
//   takes PRESCALE clock cycles. When the terminal tick is taken, done pulses
//   for one cycle. The timer then either returns to idle (one-shot) or reloads
//   (auto-reload).
//
// Parameters
//   WIDTH     bit width of the terminal value and the running count
//   PRESCALE  clk cycles per count tick (>= 1)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   request a run; only looked at while idle
//   load_val   in   terminal count, captured while idle
//   mode       in   0 = one-shot, 1 = auto-reload; captured while idle
//   pause      in   level; freezes count and prescaler while high
//   abort      in   return to idle at once, no done pulse
//   busy       out  high while running or paused
//   done       out  one-cycle pulse per completed interval
//   count_out  out  current running count
module interval_timer #(
  parameter int WIDTH    = 11,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count_out
);

  localparam int PW = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic [WIDTH-1:0] term, term_nxt;
  logic [PW-1:0]    presc, presc_nxt;
  logic             mode_q, mode_nxt;
  logic             done_nxt;
  logic             tick;

  // A count step happens on the last prescaler cycle of each step.
  assign tick      = (presc == PRESC_LAST);
  assign busy      = (state != S_IDLE);
  assign count_out = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      count  <= '0;
      term   <= '0;
      presc  <= '0;
      mode_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      term   <= term_nxt;
      presc  <= presc_nxt;
      mode_q <= mode_nxt;
      done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    term_nxt  = term;
    presc_nxt = presc;
    mode_nxt  = mode_q;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        // Keep capturing the run parameters, so that the values present
        // alongside start are the ones that stick.
        term_nxt  = load_val;
        mode_nxt  = mode;
        count_nxt = '0;
        presc_nxt = '0;
        if (start && !abort) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nxt = S_IDLE;
          count_nxt = '0;
          presc_nxt = '0;
        end else if (pause) begin
          // No tick is taken on the cycle that enters the pause.
          state_nxt = S_PAUSED;
        end else if (tick) begin
          presc_nxt = '0;
          if (count == term) begin
            done_nxt  = 1'b1;
            count_nxt = '0;
            if (!mode_q) begin
              state_nxt = S_IDLE;
            end
          end else begin
            count_nxt = count + 1'b1;
          end
        end else begin
          presc_nxt = presc + 1'b1;
        end
      end
      S_PAUSED: begin
        if (abort) begin
          state_nxt = S_IDLE;
          count_nxt = '0;
          presc_nxt = '0;
        end else if (!pause) begin
          state_nxt = S_RUN;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        count_nxt = '0;
        presc_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_interval_timer.sv
// tb_interval_timer
//   Drives two timers with the same inputs: one with PRESCALE = 1 and one with
//   PRESCALE = 4. A reference model tracks each timer as a number of unpaused
//   cycles elapsed in the current interval. The expected count is that number
//   divided by the prescale factor. The interval completes when the elapsed
//   count reaches (term+1)*P. Every cycle, the outputs of both timers are
//   compared against the model. Directed scenarios also check hand-computed
//   values at fixed points.
module tb_interval_timer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [10:0] load_val;
  logic        mode;
  logic        pause;
  logic        abort;
  wire  [1:0]  busy;
  wire  [1:0]  done;
  wire  [10:0] cnt0;
  wire  [10:0] cnt1;

  int vectors;
  int miscompares;

  interval_timer #(.WIDTH(11), .PRESCALE(1)) u_p1 (
    .clk(clk), .rst(rst), .start(start), .load_val(load_val), .mode(mode),
    .pause(pause), .abort(abort), .busy(busy[0]), .done(done[0]),
    .count_out(cnt0)
  );

  interval_timer #(.WIDTH(11), .PRESCALE(4)) u_p4 (
    .clk(clk), .rst(rst), .start(start), .load_val(load_val), .mode(mode),
    .pause(pause), .abort(abort), .busy(busy[1]), .done(done[1]),
    .count_out(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  int m_p    [2] = '{1, 4};
  int m_term [2];
  int m_el   [2];
  bit m_run  [2];
  bit m_rel  [2];
  bit m_psd  [2];
  bit m_done [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i] = 0; m_rel[i] = 0; m_psd[i] = 0; m_done[i] = 0;
        m_term[i] = 0; m_el[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_done[i] = 0;
        if (!m_run[i]) begin
          if (start && !abort) begin
            m_run[i]  = 1;
            m_term[i] = int'(load_val);
            m_rel[i]  = mode;
            m_el[i]   = 0;
            m_psd[i]  = 0;
          end
        end else if (abort) begin
          m_run[i] = 0; m_el[i] = 0; m_psd[i] = 0;
        end else if (pause) begin
          m_psd[i] = 1;
        end else if (m_psd[i]) begin
          m_psd[i] = 0;
        end else begin
          m_el[i]++;
          if (m_el[i] == (m_term[i] + 1) * m_p[i]) begin
            m_done[i] = 1;
            m_el[i]   = 0;
            if (!m_rel[i]) m_run[i] = 0;
          end
        end
      end
    end
  end

  // Compare both timers against the model every cycle, away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("p1_busy",  int'(busy[0]), int'(m_run[0]));
      chk("p1_done",  int'(done[0]), int'(m_done[0]));
      chk("p1_count", int'(cnt0),    m_el[0] / m_p[0]);
      chk("p4_busy",  int'(busy[1]), int'(m_run[1]));
      chk("p4_done",  int'(done[1]), int'(m_done[1]));
      chk("p4_count", int'(cnt1),    m_el[1] / m_p[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Return both timers to idle.
  task automatic sync();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  int busy_n;
  int done_n;

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; start = 1'b0; load_val = '0; mode = 1'b0; pause = 1'b0;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy",  int'(busy), 0);
    chk("rst_done",  int'(done), 0);
    chk("rst_count", int'(cnt0) + int'(cnt1), 0);
    rst = 1'b0;
    tick();

    // 1: one-shot, P=1, load 5.
    sync();
    load_val = 11'd5; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 6; j++) begin
      if (j > 0) tick();
      chk("t1_busy",  int'(busy[0]), 1);
      chk("t1_count", int'(cnt0), j);
      chk("t1_done",  int'(done[0]), 0);
    end
    tick();
    chk("t1_done_pulse", int'(done[0]), 1);
    chk("t1_busy_fall",  int'(busy[0]), 0);
    tick();
    chk("t1_done_clear", int'(done[0]), 0);

    // 2: auto-reload, P=1, load 3, then abort.
    sync();
    load_val = 11'd3; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_count0", int'(cnt0), 0);
    for (int j = 1; j <= 12; j++) begin
      tick();
      chk("t2_busy",  int'(busy[0]), 1);
      chk("t2_done",  int'(done[0]), (j % 4 == 0) ? 1 : 0);
      chk("t2_count", int'(cnt0), j % 4);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t2_abort_busy", int'(busy[0]), 0);
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("t2_post_done", int'(done[0]), 0);
      chk("t2_post_busy", int'(busy[0]), 0);
    end

    // 3: one-shot, P=4, load 2.
    sync();
    load_val = 11'd2; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 12; j++) begin
      if (j > 0) tick();
      chk("t3_busy",  int'(busy[1]), 1);
      chk("t3_count", int'(cnt1), j / 4);
    end
    tick();
    chk("t3_done", int'(done[1]), 1);
    chk("t3_idle", int'(busy[1]), 0);

    // 4: one-shot, P=1, load 7. Pause at count 3 freezes it for 10 cycles.
    sync();
    load_val = 11'd7; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    busy_n = int'(busy[0]);
    done_n = 0;
    for (int j = 1; j <= 30; j++) begin
      pause = (j >= 4 && j <= 12);
      tick();
      busy_n += int'(busy[0]);
      done_n += int'(done[0]);
      if (j >= 3 && j <= 13) chk("t4_hold3", int'(cnt0), 3);
      if (j >= 4 && j <= 13) chk("t4_busy_paused", int'(busy[0]), 1);
    end
    pause = 1'b0;
    chk("t4_busy_total", busy_n, 18);
    chk("t4_done_count", done_n, 1);

    // 5: start together with abort never starts a run.
    sync();
    load_val = 11'd3; mode = 1'b0; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t5_sa_busy", int'(busy), 0);
    tick();
    chk("t5_sa_busy2", int'(busy), 0);

    // 5: start while busy is ignored. The original term of 3 holds (4 busy cycles).
    load_val = 11'd3; mode = 1'b0; start = 1'b1;
    tick();
    busy_n = int'(busy[0]);
    done_n = 0;
    for (int j = 1; j <= 10; j++) begin
      start = (j <= 2); load_val = 11'd1; mode = 1'b1;
      tick();
      busy_n += int'(busy[0]);
      done_n += int'(done[0]);
      if (j == 2) chk("t5_count2", int'(cnt0), 2);
    end
    start = 1'b0;
    chk("t5_busy_total", busy_n, 4);
    chk("t5_done_count", done_n, 1);

    // 5b: start held through the done cycle restarts after a one-cycle gap.
    sync();
    load_val = 11'd1; mode = 1'b0; start = 1'b1;
    tick();
    chk("t5b_run0", int'(busy[0]), 1);
    tick();
    chk("t5b_count1", int'(cnt0), 1);
    tick();
    chk("t5b_gap_busy", int'(busy[0]), 0);
    chk("t5b_gap_done", int'(done[0]), 1);
    tick();
    chk("t5b_restart_busy", int'(busy[0]), 1);
    chk("t5b_restart_done", int'(done[0]), 0);
    start = 1'b0;

    // 6: async reset mid-run at count 4 clears the outputs at once.
    sync();
    load_val = 11'd7; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("t6_count4", int'(cnt0), 4);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy",  int'(busy), 0);
    chk("t6_rst_count", int'(cnt0) + int'(cnt1), 0);
    chk("t6_rst_done",  int'(done), 0);
    #2 rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("t6_post_done", int'(done[0]), 0);
      chk("t6_post_busy", int'(busy[0]), 0);
    end

    // 6: one-shot with load 0 at P=1: one busy cycle, then done.
    load_val = 11'd0; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_z_busy",  int'(busy[0]), 1);
    chk("t6_z_count", int'(cnt0), 0);
    tick();
    chk("t6_z_done",  int'(done[0]), 1);
    chk("t6_z_idle",  int'(busy[0]), 0);
    tick();
    chk("t6_z_clear", int'(done[0]), 0);
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
